// File: rtl/wb_daq_channel_arbiter.sv
// Round-robin arbiter that shares one wb_daq_bus_master between four DAQ channel FIFOs.
// Each grant is capped at MAX_BURST words, and a burst ends early when the channel empties or is disabled.
//
// state | meaning
// IDLE  | wait for bus master idle and any channel request
// ARB   | pick next requesting channel after last_grant, latch address/select
// START | master_start high for this one cycle
// RUN   | bus master transferring; pop FIFO on data_done, wait for busy to fall
module wb_daq_channel_arbiter #(
  parameter int              dw            = 32,
  parameter int              aw            = 32,
  parameter logic [aw-1:0]   BASE_ADDRESS  = '0,
  parameter logic [aw-1:0]   VECTOR_STRIDE = aw'(32'h0000_0010),
  parameter int              MAX_BURST     = 8
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [3:0]      channel_enable,
  input  logic [4*dw-1:0] channel_control,
  input  logic [3:0]      fifo_empty,
  input  logic [4*dw-1:0] fifo_data,
  output logic [3:0]      fifo_rd,
  output logic            master_start,
  output logic [aw-1:0]   master_address,
  output logic [1:0]      master_channel_select,
  output logic [dw-1:0]   master_channel_control,
  output logic [dw-1:0]   master_data_wr,
  output logic            master_fifo_empty,
  input  logic            master_data_done,
  input  logic            master_busy,
  output logic [1:0]      grant,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t     state;
  logic [1:0] last_grant;
  logic [7:0] burst_cnt;
  logic [3:0] req;
  logic [1:0] next_grant;
  logic [1:0] cand;
  logic       found;
  logic       in_xfer;
  logic       burst_full;

  assign req        = channel_enable & ~fifo_empty;
  assign in_xfer    = (state == START) || (state == RUN);
  assign burst_full = (burst_cnt >= BURST_MAX);
  assign busy       = (state != IDLE);

  // Search last_grant+1 .. last_grant+4; the +4 step wraps back to last_grant itself.
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && req[cand]) begin
        next_grant = cand;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state                 <= IDLE;
      grant                 <= 2'd0;
      last_grant            <= 2'd3;
      burst_cnt             <= 8'd0;
      master_start          <= 1'b0;
      master_address        <= '0;
      master_channel_select <= 2'd0;
    end else begin
      master_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!master_busy && (|req))
            state <= ARB;
        end
        ARB: begin
          burst_cnt <= 8'd0;
          // A found request implies the chosen FIFO is non-empty, which the bus master relies on.
          if (found && !master_busy) begin
            grant                 <= next_grant;
            master_channel_select <= next_grant;
            master_address        <= BASE_ADDRESS + aw'(next_grant) * VECTOR_STRIDE;
            master_start          <= 1'b1;
            state                 <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (master_data_done && !burst_full)
            burst_cnt <= burst_cnt + 8'd1;
          if (!master_busy) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pop is suppressed during reset so a data_done coinciding with reset cannot consume a word.
  always_comb begin
    fifo_rd = 4'b0000;
    if ((state == RUN) && master_data_done && !wb_rst)
      fifo_rd[grant] = 1'b1;
  end

  assign master_data_wr         = in_xfer ? fifo_data[int'(grant)*dw +: dw] : '0;
  assign master_channel_control = in_xfer ? channel_control[int'(grant)*dw +: dw] : '0;
  assign master_fifo_empty      = in_xfer &
                                  (fifo_empty[grant] | ~channel_enable[grant] | burst_full);

endmodule
